des_perm_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational DES IP/IP^-1 permutation stage.
- Applies the FIPS 46-3 initial permutation (IP), final permutation (IP^-1) or bypass to NUM_LANES parallel 64-bit blocks per beat.
- Registers the result through PIPE_DEPTH stages with valid/ready backpressure.
- Sits between the USB receive buffer and the DES round engine, and between the round engine and the transmit buffer. It keeps a beat counter for the controller.

---
 rtl/des_pkg.sv | 67 ++++++
 rtl/des_perm_lane.sv | 26 ++
 rtl/des_perm_pipe.sv | 153 +++++++++++++++
 tb/tb_des_perm_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared definitions for the DES permutation pipeline:
//   des_mode_t - per-beat operation select (bypass, IP, IP^-1, reserved)
//   IP_SRC     - initial permutation as a source-bit table
//   FP_SRC     - final permutation (IP^-1) as a source-bit table
//   des_ip()   - applies IP to one 64-bit block
//   des_fp()   - applies IP^-1 to one 64-bit block
// Bit numbering: DES bit 1 is bit 63 of the 64-bit block, DES bit 64 is bit 0.
// -----------------------------------------------------------------------------
package des_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    IP     = 2'b01,
    FP     = 2'b10,
    RSVD   = 2'b11
  } des_mode_t;

  // Entry [k] is the input bit index (0 = LSB) that lands on output bit k.
  // Listed from output bit 63 downwards, i.e. in DES table order with each
  // DES bit number n already converted to the vector index 64-n.
  localparam int IP_SRC [63:0] = '{
     6, 14, 22, 30, 38, 46, 54, 62,
     4, 12, 20, 28, 36, 44, 52, 60,
     2, 10, 18, 26, 34, 42, 50, 58,
     0,  8, 16, 24, 32, 40, 48, 56,
     7, 15, 23, 31, 39, 47, 55, 63,
     5, 13, 21, 29, 37, 45, 53, 61,
     3, 11, 19, 27, 35, 43, 51, 59,
     1,  9, 17, 25, 33, 41, 49, 57
  };

  localparam int FP_SRC [63:0] = '{
    24, 56, 16, 48,  8, 40,  0, 32,
    25, 57, 17, 49,  9, 41,  1, 33,
    26, 58, 18, 50, 10, 42,  2, 34,
    27, 59, 19, 51, 11, 43,  3, 35,
    28, 60, 20, 52, 12, 44,  4, 36,
    29, 61, 21, 53, 13, 45,  5, 37,
    30, 62, 22, 54, 14, 46,  6, 38,
    31, 63, 23, 55, 15, 47,  7, 39
  };

  function automatic logic [63:0] des_ip(input logic [63:0] blk);
    logic [63:0] res;
    logic [5:0]  k;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      k      = 6'(i);
      res[k] = blk[IP_SRC[k][5:0]];
    end
    return res;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] blk);
    logic [63:0] res;
    logic [5:0]  k;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      k      = 6'(i);
      res[k] = blk[FP_SRC[k][5:0]];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_perm_lane.sv
// -----------------------------------------------------------------------------
// des_perm_lane
// Combinational permutation of one 64-bit block.
// Ports:
//   mode - operation select; IP and FP permute, BYPASS and RSVD pass through
//   din  - input block (DES bit 1 at bit 63)
//   dout - permuted block, same bit numbering
// -----------------------------------------------------------------------------
module des_perm_lane
  import des_pkg::*;
(
  input  des_mode_t   mode,
  input  logic [63:0] din,
  output logic [63:0] dout
);

  always_comb begin
    dout = din;
    case (mode)
      IP:      dout = des_ip(din);
      FP:      dout = des_fp(din);
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/des_perm_pipe.sv
// -----------------------------------------------------------------------------
// des_perm_pipe
// Pipelined DES IP / IP^-1 / bypass stage over NUM_LANES parallel 64-bit blocks
// with valid/ready flow control and an accepted-beat counter.
// Parameters:
//   NUM_LANES  - 64-bit blocks per beat (1, 2 or 4)
//   PIPE_DEPTH - register stages between input and output (1..4)
//   CNT_W      - width of beat_count
// Ports:
//   clk, rst          - clock (rising edge), synchronous active-high reset
//   in_valid/in_ready - input handshake; in_mode selects the operation
//   in_data           - lane i at bits [64i+63:64i]
//   out_valid/out_ready, out_data, out_mode - output handshake and payload;
//                       out_mode reports the reserved mode as 00
//   err_mode          - one-cycle pulse after a reserved-mode beat is accepted
//   clr_count         - synchronous clear of beat_count, wins over increment
//   beat_count        - number of accepted input beats, wraps
// -----------------------------------------------------------------------------
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int NUM_LANES  = 1,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic [64*NUM_LANES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [64*NUM_LANES-1:0] out_data,
  output logic [1:0]              out_mode,
  output logic                    err_mode,
  input  logic                    clr_count,
  output logic [CNT_W-1:0]        beat_count
);

  localparam int DW = 64 * NUM_LANES;

  logic [DW-1:0]         perm_data;
  logic [1:0]            perm_mode;
  logic [PIPE_DEPTH-1:0] vld_vec;
  logic [PIPE_DEPTH-1:0] ld;
  logic                  accept;

  // Input side: per-lane permutation feeding stage 0
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    des_perm_lane u_lane (
      .mode (des_mode_t'(in_mode)),
      .din  (in_data[64*g +: 64]),
      .dout (perm_data[64*g +: 64])
    );
  end

  // Reserved beats travel as bypass so downstream never sees mode 11.
  assign perm_mode = (in_mode == RSVD) ? BYPASS : in_mode;

  // A stage may load unless it and every stage after it hold a beat while the
  // sink is stalled. Written per stage in closed form so the ready chain has
  // no self-referencing vector.
  always_comb begin
    logic full_tail;
    ld        = '0;
    full_tail = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      full_tail = 1'b1;
      for (int j = k; j < PIPE_DEPTH; j++) begin
        full_tail = full_tail & vld_vec[j];
      end
      ld[k] = ~full_tail | out_ready;
    end
  end

  assign in_ready = ld[0];
  assign accept   = in_valid & in_ready;

  // Pipeline stages: stage k takes the upstream slot whenever ld[k]; an
  // empty upstream slot simply moves a bubble forward.
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    logic          vld;
    logic [1:0]    mode;
    logic [DW-1:0] data;
    logic          up_vld;
    logic [1:0]    up_mode;
    logic [DW-1:0] up_data;

    if (k == 0) begin : g_src
      assign up_vld  = in_valid;
      assign up_mode = perm_mode;
      assign up_data = perm_data;
    end else begin : g_src
      assign up_vld  = g_stage[k-1].vld;
      assign up_mode = g_stage[k-1].mode;
      assign up_data = g_stage[k-1].data;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= 1'b0;
      end else if (ld[k]) begin
        vld <= up_vld;
      end
    end

    // Only the output stage clears its payload on reset; inner payload
    // registers are qualified by their valid bit.
    if (k == PIPE_DEPTH - 1) begin : g_data
      always_ff @(posedge clk) begin
        if (rst) begin
          mode <= '0;
          data <= '0;
        end else if (ld[k] && up_vld) begin
          mode <= up_mode;
          data <= up_data;
        end
      end
    end else begin : g_data
      always_ff @(posedge clk) begin
        if (ld[k] && up_vld) begin
          mode <= up_mode;
          data <= up_data;
        end
      end
    end

    assign vld_vec[k] = vld;
  end

  // Output side: driven straight from the last stage registers
  assign out_valid = g_stage[PIPE_DEPTH-1].vld;
  assign out_mode  = g_stage[PIPE_DEPTH-1].mode;
  assign out_data  = g_stage[PIPE_DEPTH-1].data;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_mode <= 1'b0;
    end else begin
      err_mode <= accept && (in_mode == RSVD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      beat_count <= '0;
    end else if (accept) begin
      beat_count <= beat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_des_perm_pipe.sv
module tb_des_perm_pipe;

  localparam int NL = 2;
  localparam int PD = 3;
  localparam int CW = 32;
  localparam int DW = 64 * NL;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    mode;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_mode = 2'b00;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [1:0]    out_mode;
  logic          err_mode;
  logic          clr_count = 1'b0;
  logic [CW-1:0] beat_count;

  int n_vec = 0;
  int n_err = 0;

  beat_t         q[$];
  logic [CW-1:0] cnt_m = '0;
  logic          err_m = 1'b0;

  always #5 clk = ~clk;

  des_perm_pipe #(.NUM_LANES(NL), .PIPE_DEPTH(PD), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mode   (out_mode),
    .err_mode   (err_mode),
    .clr_count  (clr_count),
    .beat_count (beat_count)
  );

  // Reference permutations built from the DES table structure: IP rows start
  // at 58,60,62,64,57,59,61,63 and step down by 8; IP^-1 is its inverse.
  function automatic logic [63:0] m_ip(input logic [63:0] d);
    int row_start [8];
    int src;
    logic [63:0] o;
    row_start = '{58, 60, 62, 64, 57, 59, 61, 63};
    o = '0;
    for (int i = 0; i < 64; i++) begin
      src = row_start[i / 8] - 8 * (i % 8);
      o[63 - i] = d[64 - src];
    end
    return o;
  endfunction

  function automatic logic [63:0] m_fp(input logic [63:0] d);
    int row_start [8];
    int src;
    logic [63:0] o;
    row_start = '{58, 60, 62, 64, 57, 59, 61, 63};
    o = '0;
    for (int i = 0; i < 64; i++) begin
      src = row_start[i / 8] - 8 * (i % 8);
      o[64 - src] = d[63 - i];
    end
    return o;
  endfunction

  function automatic beat_t m_beat(input logic [DW-1:0] d, input logic [1:0] m);
    beat_t b;
    logic [63:0] x;
    b = '0;
    for (int l = 0; l < NL; l++) begin
      x = d[l*64 +: 64];
      if (m == 2'b01) x = m_ip(x);
      else if (m == 2'b10) x = m_fp(x);
      b.data[l*64 +: 64] = x;
    end
    b.mode = (m == 2'b11) ? 2'b00 : m;
    return b;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Send one beat and stop at the sample point where it must be on the output.
  task automatic send1(input logic [1:0] m, input logic [DW-1:0] d);
    tick();
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    repeat (PD - 1) tick();
    smp();
  endtask

  // Scoreboard: inputs are stable at the falling edge, so this sees exactly
  // what the DUT will sample at the next rising edge.
  always @(negedge clk) begin
    beat_t e;
    logic  acc;
    logic  exp_rdy;
    if (rst) begin
      q.delete();
      cnt_m = '0;
      err_m = 1'b0;
    end else begin
      exp_rdy = !((q.size() == PD) && !out_ready);
      chk("sb_in_ready", DW'(in_ready), DW'(exp_rdy));
      chk("sb_beat_count", DW'(beat_count), DW'(cnt_m));
      chk("sb_err_mode", DW'(err_mode), DW'(err_m));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("sb_stale_beat", DW'(out_valid), DW'(1'b0));
        end else begin
          e = q[0];
          chk("sb_out_data", out_data, e.data);
          chk("sb_out_mode", DW'(out_mode), DW'(e.mode));
          if (out_ready) void'(q.pop_front());
        end
      end
      acc = in_valid && exp_rdy;
      if (acc) q.push_back(m_beat(in_data, in_mode));
      err_m = acc && (in_mode == 2'b11);
      if (clr_count) cnt_m = '0;
      else if (acc) cnt_m = cnt_m + 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] snap;
    int nout;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    smp();
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_mode", DW'(out_mode), '0);
    chk("rst_err_mode", DW'(err_mode), '0);
    chk("rst_beat_count", DW'(beat_count), '0);
    chk("rst_in_ready", DW'(in_ready), DW'(1'b1));

    // Known vector with explicit latency
    tick();
    in_valid = 1'b1;
    in_mode  = 2'b01;
    in_data  = {64'h0, 64'h0123456789ABCDEF};
    tick();
    in_valid = 1'b0;
    smp();
    chk("lat_c1", DW'(out_valid), '0);
    tick(); smp();
    chk("lat_c2", DW'(out_valid), '0);
    tick(); smp();
    chk("lat_c3", DW'(out_valid), DW'(1'b1));
    chk("kv_ip_lane0", DW'(out_data[63:0]), DW'(64'hCC00CCFFF0AAF0AA));
    chk("kv_ip_lane1", DW'(out_data[127:64]), '0);
    chk("kv_ip_mode", DW'(out_mode), DW'(2'b01));

    send1(2'b10, {64'h0, 64'hCC00CCFFF0AAF0AA});
    chk("kv_fp_lane0", DW'(out_data[63:0]), DW'(64'h0123456789ABCDEF));
    chk("kv_fp_mode", DW'(out_mode), DW'(2'b10));

    send1(2'b01, {64'h0123456789ABCDEF, 64'h0});
    chk("kv_lane1_ip", DW'(out_data[127:64]), DW'(64'hCC00CCFFF0AAF0AA));
    chk("kv_lane1_other", DW'(out_data[63:0]), '0);

    // Walking one: bit 6 is DES bit 58, which IP places at DES bit 1
    send1(2'b01, {64'h0, 64'h40});
    chk("walk_lane0", out_data, {64'h0, 64'h8000000000000000});
    send1(2'b01, {64'h40, 64'h0});
    chk("walk_lane1", out_data, {64'h8000000000000000, 64'h0});

    // Reserved mode
    tick();
    in_valid = 1'b1;
    in_mode  = 2'b11;
    in_data  = {64'hFFFF0000FFFF0000, 64'hFFFF0000FFFF0000};
    tick();
    in_valid = 1'b0;
    smp();
    chk("rsvd_err_pulse", DW'(err_mode), DW'(1'b1));
    tick(); smp();
    chk("rsvd_err_clear", DW'(err_mode), '0);
    tick(); smp();
    chk("rsvd_valid", DW'(out_valid), DW'(1'b1));
    chk("rsvd_data", out_data, {64'hFFFF0000FFFF0000, 64'hFFFF0000FFFF0000});
    chk("rsvd_mode", DW'(out_mode), '0);

    // Clear wins over a simultaneous accept
    tick();
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = rnd_data();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    in_data   = rnd_data();
    smp();
    chk("clr_with_accept", DW'(beat_count), '0);
    tick();
    in_valid = 1'b0;
    smp();
    chk("count_after_clr", DW'(beat_count), DW'(1));
    repeat (PD + 1) tick();

    // Reset with two beats in flight, the older one already on the output
    in_valid = 1'b1;
    in_mode  = 2'b01;
    in_data  = rnd_data();
    tick();
    in_data  = rnd_data();
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    smp();
    chk("midrst_out_valid", DW'(out_valid), '0);
    chk("midrst_beat_count", DW'(beat_count), '0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_in_ready", DW'(in_ready), DW'(1'b1));
    for (int i = 0; i < 6; i++) begin
      tick(); smp();
      chk("midrst_no_stale", DW'(out_valid), '0);
    end

    // Streaming 100 beats with out_ready high
    tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    nout = 0;
    for (int i = 0; i < 100 + PD; i++) begin
      in_valid = (i < 100);
      if (i < 100) begin
        in_mode = 2'($urandom_range(0, 2));
        in_data = rnd_data();
      end
      smp();
      if (i >= PD && out_valid) nout++;
      tick();
    end
    in_valid = 1'b0;
    smp();
    chk("stream_count", DW'(beat_count), DW'(100));
    chk("stream_back_to_back", DW'(nout), DW'(100));

    // Backpressure: out_ready low for 10 cycles with in_valid high
    tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    snap      = '0;
    for (int i = 0; i < 10; i++) begin
      in_mode = 2'($urandom_range(0, 3));
      in_data = rnd_data();
      smp();
      if (i == 5) snap = out_data;
      tick();
    end
    smp();
    chk("bp_accepted", DW'(beat_count), DW'(PD));
    chk("bp_in_ready", DW'(in_ready), '0);
    chk("bp_out_valid", DW'(out_valid), DW'(1'b1));
    chk("bp_stable", out_data, snap);
    tick();
    out_ready = 1'b1;
    smp();
    chk("bp_release_ready", DW'(in_ready), DW'(1'b1));
    for (int i = 0; i < 4; i++) begin
      tick(); smp();
      chk("bp_no_bubble", DW'(out_valid), DW'(1'b1));
    end
    tick();
    in_valid = 1'b0;
    repeat (PD + 2) tick();

    // Random traffic with random stalls, modes and clears
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_data   = rnd_data();
      clr_count = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid  = 1'b0;
    clr_count = 1'b0;
    out_ready = 1'b1;
    repeat (PD + 3) tick();
    smp();
    chk("drain_empty", DW'(out_valid), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
